alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Issue and writeback controller that sits directly upstream of the 4-bit ALU. It accepts one operation at a time over a valid/ready handshake and reads operands from a 4-entry × 4-bit register file. It drives registered `S`/`A`/`B` into the ALU, captures the ALU's 5-bit result, writes it back to the register file, and presents it downstream over a second valid/ready handshake.

## Interface
- `RF_DEPTH`, 4: register file entries. Fixed; index width is 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation request valid.
- `in_ready` out 1: sequencer can accept an operation.
- `in_op` in 4: ALU select code, passed unchanged to `alu_s`.
- `in_ra`, `in_rb` in 2 each: operand register indices.
- `in_rd` in 2: destination register index.
- `in_wb` in 1: write the result back to `rf[in_rd]` when 1.
- `ld_en`, `ld_addr`, `ld_data` in 1/2/4: direct register-file load port.
- `alu_s`, `alu_a`, `alu_b` out 4 each: registered ALU inputs.
- `alu_result` in 5: combinational ALU output.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out 5: captured ALU result.
- `out_rd` out 2: destination index of the result.
- `carry` out 1: `alu_result[4]` of the last completed op.

## Operation
- States are IDLE, EXEC and RESP. Reset enters IDLE.
- IDLE: `in_ready`=1.
  - On `in_valid & in_ready`, latch `alu_s<=in_op`, `alu_a<=rf[in_ra]`, `alu_b<=rf[in_rb]`, and latch rd/wb. Go to EXEC.
- EXEC (exactly one cycle):
  - Capture `out_data<=alu_result` and `carry<=alu_result[4]`.
  - If wb, write `rf[rd]<=alu_result[3:0]`.
  - Go to RESP.
- RESP: `out_valid`=1. On `out_ready`, go to IDLE. Otherwise hold, with `out_data` and `out_rd` stable.
- `in_ready` is 0 in EXEC and RESP. No overlap between operations.
- Writeback truncates to bits [3:0]; bit 4 is visible only in `out_data[4]` and `carry`.
- Operand reads in IDLE see all writes committed on earlier edges. There is no same-edge forwarding.
- `ld_en` writes `rf[ld_addr]<=ld_data` on any edge, in any state.
  - If the load collides with an EXEC writeback to the same index, the writeback wins and the load is dropped.
  - Different indices are both written.
- `alu_s`/`alu_a`/`alu_b` hold their values outside IDLE acceptance.

## Timing
- Reset values:
  - State IDLE.
  - `rf[*]`, `alu_s`, `alu_a`, `alu_b`, `out_data`, `out_rd`, `carry` and `out_valid` all 0.
  - `in_ready`=0 while `rst_n`=0, and 1 from the first cycle after release.
- Latency:
  - Accept on edge N, result captured on edge N+1, `out_valid` high in cycle N+1.
  - With `out_ready` held high, the next accept is on edge N+3. Peak throughput is 1 op per 3 cycles.
- `alu_result` must settle within one cycle of the `alu_*` registers changing.
- Reset asserted mid-operation aborts immediately:
  - A pending writeback is lost.
  - `out_valid` drops asynchronously.
  - The register file clears.
- `out_valid` never drops without `out_ready`, except on reset.

## Configuration
- `ALU_SEQ_IMM_EN` defined:
  - Adds the ports `in_imm_en` (in 1) and `in_imm` (in 4).
  - When `in_imm_en`=1 at accept, `alu_b<=in_imm` instead of `rf[in_rb]`.
- Undefined: these ports are absent and `alu_b` always comes from `rf[in_rb]`.

## Structure
- A shared package `alu_seq_pkg` holds:
  - The state enum.
  - The `RF_IDX_W`=2, `DATA_W`=4 and `RES_W`=5 constants.
  - Named opcode constants `OP_ADD`=0 through `OP_OR`=15, for the bench and for callers.
- One natural sub-module, `alu_seq_regfile`: 4×4 registers with two asynchronous read ports and two prioritised write ports (writeback over load).

## Test plan
- Add:
  - Stimulus: load r0=5 and r1=3, then op 0000 with ra=0, rb=1, rd=2, wb=1.
  - Response: `out_data`=5'b01000 one cycle after accept, r2=8, `carry`=0.
- Subtract with wrap:
  - Stimulus: op 0001 with ra=1 (3), rb=0 (5), rd=3.
  - Response: `out_data`=5'b11110, r3=4'b1110, `carry`=1.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 4 cycles during RESP.
  - Response: `out_valid`, `out_data` and `out_rd` stable; `in_ready`=0 throughout; IDLE on the cycle after `out_ready`=1.
- Collision:
  - Stimulus: `ld_en` to r2 with 4'hF on the same edge as an EXEC writeback of 8 to r2.
  - Response: r2=8. A simultaneous load to r1 still lands.
- Reset mid-op:
  - Stimulus: drop `rst_n` during EXEC.
  - Response: `out_valid`=0, `rf` all 0, state IDLE, and no writeback observed after release.
- With `ALU_SEQ_IMM_EN`:
  - Stimulus: op 0000, ra=0 (5), `in_imm_en`=1, `in_imm`=4'h2.
  - Response: `out_data`=7 and `alu_b`=2.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants, state encoding and opcode names for the ALU operation sequencer.
package alu_seq_pkg;

  localparam int RF_DEPTH = 4;
  localparam int RF_IDX_W = 2;
  localparam int DATA_W   = 4;
  localparam int RES_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Select codes understood by the downstream 4-bit ALU.
  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_INC    = 4'd2;
  localparam logic [3:0] OP_DEC    = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_NAND   = 4'd5;
  localparam logic [3:0] OP_XOR    = 4'd6;
  localparam logic [3:0] OP_XNOR   = 4'd7;
  localparam logic [3:0] OP_NOT_A  = 4'd8;
  localparam logic [3:0] OP_NOT_B  = 4'd9;
  localparam logic [3:0] OP_PASS_A = 4'd10;
  localparam logic [3:0] OP_PASS_B = 4'd11;
  localparam logic [3:0] OP_SHL    = 4'd12;
  localparam logic [3:0] OP_SHR    = 4'd13;
  localparam logic [3:0] OP_NOR    = 4'd14;
  localparam logic [3:0] OP_OR     = 4'd15;

  // Writeback keeps only the data bits; bit 4 lives on in out_data/carry.
  function automatic logic [DATA_W-1:0] wb_trunc(input logic [RES_W-1:0] res);
    return res[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x4 register file: two asynchronous read ports, load port and writeback port.
// Writeback has priority over the load when both target the same entry.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [RF_IDX_W-1:0]          ra_i,
  input  logic [RF_IDX_W-1:0]          rb_i,
  output logic [DATA_W-1:0]            a_o,
  output logic [DATA_W-1:0]            b_o,
  input  logic                         wb_en_i,
  input  logic [RF_IDX_W-1:0]          wb_addr_i,
  input  logic [DATA_W-1:0]            wb_data_i,
  input  logic                         ld_en_i,
  input  logic [RF_IDX_W-1:0]          ld_addr_i,
  input  logic [DATA_W-1:0]            ld_data_i,
  output logic [RF_DEPTH*DATA_W-1:0]   dump_o
);

  logic [DATA_W-1:0] rf_q [RF_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        if (wb_en_i && (wb_addr_i == RF_IDX_W'(i))) begin
          rf_q[i] <= wb_data_i;
        end else if (ld_en_i && (ld_addr_i == RF_IDX_W'(i))) begin
          rf_q[i] <= ld_data_i;
        end
      end
    end
  end

  // No forwarding: reads only see values committed on earlier edges.
  assign a_o = rf_q[ra_i];
  assign b_o = rf_q[rb_i];

  for (genvar g = 0; g < RF_DEPTH; g++) begin : g_dump
    assign dump_o[g*DATA_W +: DATA_W] = rf_q[g];
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/writeback controller in front of a 4-bit ALU: IDLE accepts, EXEC captures, RESP presents.
// Define ALU_SEQ_IMM_EN to add the in_imm_en/in_imm immediate operand ports.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  // Both handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // once raised, valid holds with stable payload until that transfer.
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  in_op,
  input  logic [RF_IDX_W-1:0]         in_ra,
  input  logic [RF_IDX_W-1:0]         in_rb,
  input  logic [RF_IDX_W-1:0]         in_rd,
  input  logic                        in_wb,
`ifdef ALU_SEQ_IMM_EN
  input  logic                        in_imm_en,
  input  logic [DATA_W-1:0]           in_imm,
`endif
  input  logic                        ld_en,
  input  logic [RF_IDX_W-1:0]         ld_addr,
  input  logic [DATA_W-1:0]           ld_data,
  output logic [3:0]                  alu_s,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  input  logic [RES_W-1:0]            alu_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RES_W-1:0]            out_data,
  output logic [RF_IDX_W-1:0]         out_rd,
  output logic                        carry,
  output logic [1:0]                  dbg_state_o,
  output logic [RF_DEPTH*DATA_W-1:0]  dbg_rf_o
);

  state_e                state_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  wb_q;
  logic                  carry_q;
  logic [3:0]            alu_s_q;
  logic [DATA_W-1:0]     alu_a_q;
  logic [DATA_W-1:0]     alu_b_q;
  logic [RES_W-1:0]      out_data_q;
  logic [RF_IDX_W-1:0]   out_rd_q;

  logic [DATA_W-1:0]     rf_a;
  logic [DATA_W-1:0]     rf_b;
  logic [DATA_W-1:0]     opnd_b;
  logic                  accept;
  logic                  wb_en;

  // in_ready_q is only ever 1 while in IDLE, so it alone qualifies acceptance.
  assign accept = in_valid & in_ready_q;
  assign wb_en  = (state_q == ST_EXEC) & wb_q;

`ifdef ALU_SEQ_IMM_EN
  assign opnd_b = in_imm_en ? in_imm : rf_b;
`else
  assign opnd_b = rf_b;
`endif

  alu_seq_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_i      (in_ra),
    .rb_i      (in_rb),
    .a_o       (rf_a),
    .b_o       (rf_b),
    .wb_en_i   (wb_en),
    .wb_addr_i (out_rd_q),
    .wb_data_i (wb_trunc(alu_result)),
    .ld_en_i   (ld_en),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data),
    .dump_o    (dbg_rf_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      wb_q        <= 1'b0;
      carry_q     <= 1'b0;
      alu_s_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            alu_s_q    <= in_op;
            alu_a_q    <= rf_a;
            alu_b_q    <= opnd_b;
            out_rd_q   <= in_rd;
            wb_q       <= in_wb;
            in_ready_q <= 1'b0;
            state_q    <= ST_EXEC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          out_data_q  <= alu_result;
          carry_q     <= alu_result[RES_W-1];
          out_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_rd      = out_rd_q;
  assign carry       = carry_q;
  assign alu_s       = alu_s_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, register-file model and expected-result queue.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [1:0]  in_ra = '0;
  logic [1:0]  in_rb = '0;
  logic [1:0]  in_rd = '0;
  logic        in_wb = 1'b0;
`ifdef ALU_SEQ_IMM_EN
  logic        in_imm_en = 1'b0;
  logic [3:0]  in_imm = '0;
`endif
  logic        ld_en = 1'b0;
  logic [1:0]  ld_addr = '0;
  logic [3:0]  ld_data = '0;
  logic [3:0]  alu_s;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [4:0]  alu_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_data;
  logic [1:0]  out_rd;
  logic        carry;
  logic [1:0]  dbg_state;
  logic [15:0] dbg_rf;

  logic [3:0]  rf_m [4];
  logic [4:0]  exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_ra       (in_ra),
    .in_rb       (in_rb),
    .in_rd       (in_rd),
    .in_wb       (in_wb),
`ifdef ALU_SEQ_IMM_EN
    .in_imm_en   (in_imm_en),
    .in_imm      (in_imm),
`endif
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .alu_s       (alu_s),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rd      (out_rd),
    .carry       (carry),
    .dbg_state_o (dbg_state),
    .dbg_rf_o    (dbg_rf)
  );

  // Behavioural 4-bit ALU with a 5-bit result (bit 4 = carry/borrow/shifted-out bit).
  function automatic logic [4:0] alu_fn(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (s)
      OP_ADD:    r = ia + ib;
      OP_SUB:    r = ia - ib;
      OP_INC:    r = ia + 1;
      OP_DEC:    r = ia - 1;
      OP_AND:    r = ia & ib;
      OP_NAND:   r = (~(ia & ib)) & 15;
      OP_XOR:    r = ia ^ ib;
      OP_XNOR:   r = (~(ia ^ ib)) & 15;
      OP_NOT_A:  r = (~ia) & 15;
      OP_NOT_B:  r = (~ib) & 15;
      OP_PASS_A: r = ia;
      OP_PASS_B: r = ib;
      OP_SHL:    r = ia * 2;
      OP_SHR:    r = ia / 2 + (ia % 2) * 16;
      OP_NOR:    r = (~(ia | ib)) & 15;
      default:   r = ia | ib;
    endcase
    return 5'(r & 31);
  endfunction

  always_comb alu_result = alu_fn(alu_s, alu_a, alu_b);

  function automatic logic [15:0] rf_pack();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = rf_m[i];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_reg(input logic [1:0] addr, input logic [3:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    rf_m[addr] = data;
    n_checks++;
    if (dbg_rf !== rf_pack()) begin
      n_errors++;
      $display("FAIL load_reg: rf=%h required %h", dbg_rf, rf_pack());
    end
  endtask

  // One complete operation; optional load during EXEC and 'stall' cycles of backpressure in RESP.
  task automatic run_op(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [1:0] rd, input logic wb, input int stall,
                        input logic le, input logic [1:0] la, input logic [3:0] ld);
    logic [4:0] exp;
    int waited;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL op_ready_timeout: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_op = op; in_ra = ra; in_rb = rb; in_rd = rd; in_wb = wb;
    out_ready = 1'b0;
    exp_q.push_back(alu_fn(op, rf_m[ra], rf_m[rb]));
    @(negedge clk);
    in_valid = 1'b0;
    ld_en = le; ld_addr = la; ld_data = ld;
    n_checks++;
    if ({alu_s, alu_a, alu_b} !== {op, rf_m[ra], rf_m[rb]}) begin
      n_errors++;
      $display("FAIL alu_inputs: s/a/b=%h/%h/%h required %h/%h/%h", alu_s, alu_a, alu_b, op, rf_m[ra], rf_m[rb]);
    end
    n_checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_errors++;
      $display("FAIL exec_handshake: in_ready/out_valid=%b%b required 00", in_ready, out_valid);
    end
    @(negedge clk);
    ld_en = 1'b0;
    exp = exp_q.pop_front();
    if (le) rf_m[la] = ld;
    if (wb) rf_m[rd] = exp[3:0];
    n_checks++;
    if ({out_valid, out_data, out_rd, carry} !== {1'b1, exp, rd, exp[4]}) begin
      n_errors++;
      $display("FAIL resp: valid/data/rd/carry=%b/%h/%h/%b required 1/%h/%h/%b",
               out_valid, out_data, out_rd, carry, exp, rd, exp[4]);
    end
    n_checks++;
    if (dbg_rf !== rf_pack()) begin
      n_errors++;
      $display("FAIL rf_after_exec: rf=%h required %h", dbg_rf, rf_pack());
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_data, out_rd, in_ready, dbg_state} !== {1'b1, exp, rd, 1'b0, ST_RESP}) begin
        n_errors++;
        $display("FAIL stall_hold: valid/data/rd/in_ready/state=%b/%h/%h/%b/%0d required 1/%h/%h/0/%0d",
                 out_valid, out_data, out_rd, in_ready, dbg_state, exp, rd, ST_RESP);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, dbg_state} !== {1'b0, 1'b1, ST_IDLE}) begin
      n_errors++;
      $display("FAIL release_idle: valid/in_ready/state=%b/%b/%0d required 0/1/%0d",
               out_valid, in_ready, dbg_state, ST_IDLE);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, carry, out_rd, out_data, alu_s, alu_a, alu_b, dbg_state} !== 28'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: in_ready=%b valid=%b carry=%b rd=%h data=%h s/a/b=%h/%h/%h state=%0d required all 0",
               in_ready, out_valid, carry, out_rd, out_data, alu_s, alu_a, alu_b, dbg_state);
    end
    n_checks++;
    if (dbg_rf !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_rf: rf=%h required 0000", dbg_rf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_add();
    load_reg(2'd0, 4'd5);
    load_reg(2'd1, 4'd3);
    run_op(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 0, 1'b0, 2'd0, 4'd0);
    n_checks++;
    if ({out_data, carry, dbg_rf[11:8]} !== {5'b01000, 1'b0, 4'd8}) begin
      n_errors++;
      $display("FAIL add_const: data/carry/r2=%b/%b/%h required 01000/0/8", out_data, carry, dbg_rf[11:8]);
    end
  endtask

  task automatic test_sub_wrap();
    run_op(OP_SUB, 2'd1, 2'd0, 2'd3, 1'b1, 0, 1'b0, 2'd0, 4'd0);
    n_checks++;
    if ({out_data, carry, dbg_rf[15:12]} !== {5'b11110, 1'b1, 4'b1110}) begin
      n_errors++;
      $display("FAIL sub_wrap_const: data/carry/r3=%b/%b/%b required 11110/1/1110", out_data, carry, dbg_rf[15:12]);
    end
  endtask

  task automatic test_backpressure();
    run_op(OP_XOR, 2'd2, 2'd3, 2'd1, 1'b0, 4, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic test_collision();
    run_op(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 0, 1'b1, 2'd2, 4'hF);
    n_checks++;
    if (dbg_rf[11:8] !== 4'd8) begin
      n_errors++;
      $display("FAIL collision_same: r2=%h required 8", dbg_rf[11:8]);
    end
    run_op(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 0, 1'b1, 2'd1, 4'h6);
    n_checks++;
    if ({dbg_rf[7:4], dbg_rf[11:8]} !== {4'h6, 4'h8}) begin
      n_errors++;
      $display("FAIL collision_diff: r1/r2=%h/%h required 6/8", dbg_rf[7:4], dbg_rf[11:8]);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    logic [4:0] exp;
    exp = alu_fn(OP_AND, rf_m[3], rf_m[2]);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = OP_AND; in_ra = 2'd3; in_rb = 2'd2; in_rd = 2'd0; in_wb = 1'b0;
    for (int c = 0; c < 40 && acc_cyc.size() < 4; c++) begin
      if (out_valid === 1'b1) begin
        n_checks++;
        if (out_data !== exp) begin
          n_errors++;
          $display("FAIL b2b_data: data=%h required %h", out_data, exp);
        end
      end
      if (in_ready === 1'b1) acc_cyc.push_back(c);
      if (acc_cyc.size() < 4) @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc_cyc.size() != 4) begin
      n_errors++;
      $display("FAIL b2b_timeout: accepts=%0d required 4", acc_cyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
          n_errors++;
          $display("FAIL b2b_spacing: cycles=%0d required 3", acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) load_reg(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      run_op(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_reset_mid_op();
    load_reg(2'd0, 4'h9);
    load_reg(2'd1, 4'h4);
    in_valid = 1'b1; in_op = OP_ADD; in_ra = 2'd0; in_rb = 2'd1; in_rd = 2'd3; in_wb = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    n_checks++;
    if ({out_valid, in_ready, dbg_state, dbg_rf} !== {1'b0, 1'b0, ST_IDLE, 16'h0000}) begin
      n_errors++;
      $display("FAIL midop_reset: valid/in_ready/state/rf=%b/%b/%0d/%h required 0/0/0/0000",
               out_valid, in_ready, dbg_state, dbg_rf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, dbg_state, dbg_rf} !== {1'b0, 1'b1, ST_IDLE, rf_pack()}) begin
      n_errors++;
      $display("FAIL midop_release: valid/in_ready/state/rf=%b/%b/%0d/%h required 0/1/0/%h",
               out_valid, in_ready, dbg_state, dbg_rf, rf_pack());
    end
  endtask

`ifdef ALU_SEQ_IMM_EN
  task automatic test_imm();
    load_reg(2'd0, 4'd5);
    load_reg(2'd1, 4'd9);
    in_valid = 1'b1; in_op = OP_ADD; in_ra = 2'd0; in_rb = 2'd1; in_rd = 2'd2; in_wb = 1'b0;
    in_imm_en = 1'b1; in_imm = 4'h2;
    @(negedge clk);
    in_valid = 1'b0; in_imm_en = 1'b0;
    n_checks++;
    if (alu_b !== 4'h2) begin
      n_errors++;
      $display("FAIL imm_alu_b: alu_b=%h required 2", alu_b);
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 5'd7}) begin
      n_errors++;
      $display("FAIL imm_result: valid/data=%b/%h required 1/07", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
`ifdef ALU_SEQ_IMM_EN
    test_imm();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
